onehot_mux_pipe: RTL and testbench
==================================

Name: onehot_mux_pipe

Overview:
- Parametrised N-to-1 one-hot-select multiplexer for routing LLR/message words between memory banks and decoder units.
- Generalises the 2:1 and 3:1 combinational muxes in width, input count and latency.
- Adds a registered pipeline of configurable depth, a valid/ready handshake with global stall, and per-beat select checking with selectable illegal-select behaviour.
- Keeps a saturating count of illegal-select events.

Parameters:
- NUM_IN, 4: number of input channels, 2..16.
- BITWIDTH, 5: data width per channel.
- PIPE_DEPTH, 2: register stages from input to output, 1..4.
- ERR_MODE, 0: illegal-select behaviour. 0 = XOR of all selected channels (legacy combine). 1 = force output data to zero.
- CNT_W, 8: width of the error counter.

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- sw_in  in  NUM_IN*BITWIDTH  packed inputs; channel k occupies bits [k*BITWIDTH +: BITWIDTH].
- in_src  in  NUM_IN  select vector; bit k selects channel k; legal only if exactly one bit is set.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- sw_out  out  BITWIDTH  selected data.
- out_valid  out  1  sw_out valid.
- out_ready  in  1  downstream accepts the beat.
- sel_err  out  1  current output beat had an illegal select; qualified by out_valid.
- err_cnt  out  CNT_W  saturating count of accepted illegal-select beats.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rstn low, asynchronous): all stage valid bits, data, sel_err and err_cnt clear to 0. Outputs read sw_out=0, out_valid=0, sel_err=0, err_cnt=0.
- Reset mid-operation discards all in-flight beats. No output beat appears until a new beat has been accepted after rstn rises.
- Stage 0 is combinational on the input side:
  - legal = in_src has exactly one bit set (popcount == 1).
  - Data = OR over k of (in_src[k] ? channel k : 0) when legal.
  - When illegal: ERR_MODE 0 gives the XOR over selected channels (all-zero if in_src == 0); ERR_MODE 1 gives 0.
  - The flag err = !legal. in_src == 0 is illegal.
- Pipeline: PIPE_DEPTH register stages, each holding {valid, data, err}.
- advance = out_ready | ~out_valid. This is a global stall: when advance=0 every stage holds.
- in_ready = advance, combinational from out_ready and out_valid.
- Accept: in_valid & in_ready. The accepted beat enters stage 1 with valid=1. On advance with no accept, stage 1 loads valid=0.
- Latency: an accepted beat appears on sw_out exactly PIPE_DEPTH cycles after acceptance, provided advance stays high. Each stall cycle adds one.
- Throughput: one beat per cycle while out_ready=1. Bubbles propagate and are squashed as soon as advance is high.
- Output holds stable (data, sel_err) while out_valid=1 and out_ready=0.
- err_cnt:
  - Increments by 1 in the cycle an illegal-select beat is accepted at the input.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority over a same-cycle increment: the result is 0 and that event is lost.
- in_src and sw_in are ignored when in_valid=0, or when in_ready=0 (beat not accepted). The counter does not increment in those cases.

Test Plan:
- Reset/latency (NUM_IN=4, BITWIDTH=5, PIPE_DEPTH=2, out_ready=1): sw_in ch0..3 = 3,7,12,31; in_src=4'b0100; in_valid pulse at cycle 0 -> out_valid=1 with sw_out=12 and sel_err=0 at cycle 2 only; rstn low at cycle 1 -> no output beat at all.
- Streaming: in_src cycles 0001,0010,0100,1000 over 4 consecutive cycles -> sw_out sequence 3,7,12,31 on consecutive cycles starting at cycle 2; err_cnt stays 0.
- Backpressure: out_ready low for 3 cycles while out_valid=1 -> sw_out holds its value, in_ready=0, no beat dropped or duplicated; after release the sequence continues in order.
- Illegal select, ERR_MODE=0: in_src=0110 with ch1=7, ch2=12 -> sw_out=11, sel_err=1, err_cnt=1; in_src=0000 -> sw_out=0, sel_err=1, err_cnt=2.
- Illegal select, ERR_MODE=1: in_src=1111 -> sw_out=0, sel_err=1.
- Counter: CNT_W=2, 5 illegal accepted beats -> err_cnt saturates at 3; err_clr together with an illegal accept -> err_cnt=0 next cycle.

Source files
------------

// File: rtl/onehot_mux_pipe.sv
// onehot_mux_pipe: N-to-1 one-hot-select multiplexer with a registered
// pipeline, valid/ready handshake under a global stall, per-beat select
// checking and a saturating illegal-select counter.
//
// Ports:
//   sys_clk    in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   sw_in      in   packed channels, channel k at [k*BITWIDTH +: BITWIDTH]
//   in_src     in   one-hot channel select
//   in_valid   in   input beat valid
//   in_ready   out  beat can be accepted this cycle (combinational)
//   sw_out     out  selected data of the output beat
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the output beat
//   sel_err    out  output beat had an illegal select
//   err_cnt    out  saturating count of accepted illegal-select beats
//   err_clr    in   synchronous clear of err_cnt (wins over an increment)
module onehot_mux_pipe #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned BITWIDTH   = 5,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned ERR_MODE   = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic [NUM_IN*BITWIDTH-1:0] sw_in,
    input  logic [NUM_IN-1:0]          in_src,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [BITWIDTH-1:0]        sw_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err,
    output logic [CNT_W-1:0]           err_cnt,
    input  logic                       err_clr
);

    localparam int unsigned LAST = PIPE_DEPTH - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One pipeline stage: beat valid, illegal-select flag and data.
    typedef struct packed {
        logic                valid;
        logic                err;
        logic [BITWIDTH-1:0] data;
    } stage_t;

    logic [BITWIDTH-1:0] or_data_c;
    logic [BITWIDTH-1:0] xor_data_c;
    logic [BITWIDTH-1:0] s0_data_c;
    logic                legal_c;
    logic                advance_c;
    logic                accept_c;

    stage_t              stage_q [PIPE_DEPTH];
    stage_t              stage_d [PIPE_DEPTH];
    logic [CNT_W-1:0]    err_cnt_q;
    logic [CNT_W-1:0]    err_cnt_d;

    // Stage 0: gather the selected channels both as OR and as XOR.
    always_comb begin
        or_data_c  = '0;
        xor_data_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_src[k]) begin
                or_data_c  = or_data_c  | sw_in[k*BITWIDTH +: BITWIDTH];
                xor_data_c = xor_data_c ^ sw_in[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign legal_c = (in_src != '0) && ((in_src & (in_src - NUM_IN'(1))) == '0);

    // Illegal selects either keep the legacy XOR combine or force zero.
    always_comb begin
        s0_data_c = or_data_c;
        if (!legal_c) begin
            s0_data_c = (ERR_MODE == 0) ? xor_data_c : '0;
        end
    end

    // Global stall: every stage moves only when the output slot frees up.
    assign advance_c = out_ready | ~stage_q[LAST].valid;
    assign accept_c  = in_valid & advance_c;
    assign in_ready  = advance_c;

    // Pipeline next state; bubbles load as all-zero so outputs stay clean.
    always_comb begin
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (advance_c) begin
            stage_d[0] = '0;
            if (accept_c) begin
                stage_d[0].valid = 1'b1;
                stage_d[0].err   = ~legal_c;
                stage_d[0].data  = s0_data_c;
            end
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Illegal-select counter: clear wins, otherwise saturating increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept_c && !legal_c && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sw_out    = stage_q[LAST].data;
    assign out_valid = stage_q[LAST].valid;
    assign sel_err   = stage_q[LAST].err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Bench for onehot_mux_pipe: three instances share stimulus (legacy XOR
// mode, zero-on-error mode, 2-bit counter). A queue-based reference model
// tracks accepted beats by age and predicts every output each cycle.
module tb_onehot_mux_pipe;

    localparam int NI    = 4;
    localparam int BW    = 5;
    localparam int DEPTH = 2;

    logic              sys_clk;
    logic              rstn;
    logic [NI*BW-1:0]  sw_in;
    logic [NI-1:0]     in_src;
    logic              in_valid;
    logic              out_ready;
    logic              err_clr;

    logic              rdy0, rdy1, rdy2;
    logic [BW-1:0]     so0, so1, so2;
    logic              ov0, ov1, ov2;
    logic              se0, se1, se2;
    logic [7:0]        ec0, ec1;
    logic [1:0]        ec2;

    onehot_mux_pipe #(.NUM_IN(NI), .BITWIDTH(BW), .PIPE_DEPTH(DEPTH), .ERR_MODE(0), .CNT_W(8)) dut0 (
        .sys_clk(sys_clk), .rstn(rstn), .sw_in(sw_in), .in_src(in_src), .in_valid(in_valid),
        .in_ready(rdy0), .sw_out(so0), .out_valid(ov0), .out_ready(out_ready),
        .sel_err(se0), .err_cnt(ec0), .err_clr(err_clr));

    onehot_mux_pipe #(.NUM_IN(NI), .BITWIDTH(BW), .PIPE_DEPTH(DEPTH), .ERR_MODE(1), .CNT_W(8)) dut1 (
        .sys_clk(sys_clk), .rstn(rstn), .sw_in(sw_in), .in_src(in_src), .in_valid(in_valid),
        .in_ready(rdy1), .sw_out(so1), .out_valid(ov1), .out_ready(out_ready),
        .sel_err(se1), .err_cnt(ec1), .err_clr(err_clr));

    onehot_mux_pipe #(.NUM_IN(NI), .BITWIDTH(BW), .PIPE_DEPTH(DEPTH), .ERR_MODE(0), .CNT_W(2)) dut2 (
        .sys_clk(sys_clk), .rstn(rstn), .sw_in(sw_in), .in_src(in_src), .in_valid(in_valid),
        .in_ready(rdy2), .sw_out(so2), .out_valid(ov2), .out_ready(out_ready),
        .sel_err(se2), .err_cnt(ec2), .err_clr(err_clr));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NI*BW-1:0] d;
        logic [NI-1:0]    s;
        int               age;
    } beat_t;

    beat_t mq[$];
    int    cnt8 = 0;
    int    cnt2 = 0;
    bit    m_adv, m_acc, m_pre;

    function automatic bit mvalid();
        return (mq.size() > 0) && (mq[0].age == DEPTH);
    endfunction

    // Expected data: XOR of all selected channels (equals the channel when
    // exactly one is selected); mode 1 zeroes anything not one-hot.
    function automatic logic [BW-1:0] exp_data(input logic [NI*BW-1:0] d, input logic [NI-1:0] s, input int mode);
        logic [BW-1:0] x;
        x = '0;
        for (int k = 0; k < NI; k++) begin
            if (s[k]) x = x ^ d[k*BW +: BW];
        end
        if (($countones(s) != 1) && (mode == 1)) x = '0;
        return x;
    endfunction

    always @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            cnt8 = 0;
            cnt2 = 0;
        end else begin
            m_pre = mvalid();
            m_adv = out_ready || !m_pre;
            m_acc = in_valid && m_adv;
            if (err_clr) begin
                cnt8 = 0;
                cnt2 = 0;
            end else if (m_acc && ($countones(in_src) != 1)) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3) cnt2++;
            end
            if (m_adv) begin
                if (m_pre) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age = mq[i].age + 1;
                if (m_acc) mq.push_back('{d: sw_in, s: in_src, age: 1});
            end
        end
    end

    // Continuous comparison against the model on the falling edge.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            bit mv;
            mv = mvalid();
            check("out_valid0", 32'(ov0), 32'(mv));
            check("out_valid1", 32'(ov1), 32'(mv));
            check("out_valid2", 32'(ov2), 32'(mv));
            check("in_ready0", 32'(rdy0), 32'(out_ready || !mv));
            check("in_ready2", 32'(rdy2), 32'(out_ready || !mv));
            if (mv) begin
                check("sw_out0", 32'(so0), 32'(exp_data(mq[0].d, mq[0].s, 0)));
                check("sw_out1", 32'(so1), 32'(exp_data(mq[0].d, mq[0].s, 1)));
                check("sw_out2", 32'(so2), 32'(exp_data(mq[0].d, mq[0].s, 0)));
                check("sel_err0", 32'(se0), 32'($countones(mq[0].s) != 1));
                check("sel_err1", 32'(se1), 32'($countones(mq[0].s) != 1));
            end
            check("err_cnt0", 32'(ec0), 32'(cnt8));
            check("err_cnt1", 32'(ec1), 32'(cnt8));
            check("err_cnt2", 32'(ec2), 32'(cnt2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge sys_clk);
        #2;
    endtask

    typedef struct {
        logic [NI-1:0] src;
        logic [BW-1:0] d_xor;
        logic [BW-1:0] d_zero;
        logic          err;
    } vec_t;

    vec_t tbl [10];
    logic [NI*BW-1:0] base_in;
    logic [BW-1:0]    stream_exp [4];
    logic [BW-1:0]    held;
    bit               found;

    initial begin
        // Channels 0..3 = 3, 7, 12, 31.
        base_in = {5'd31, 5'd12, 5'd7, 5'd3};
        stream_exp[0] = 5'd3;  stream_exp[1] = 5'd7;
        stream_exp[2] = 5'd12; stream_exp[3] = 5'd31;

        tbl[0] = '{4'b0001, 5'd3,  5'd3,  1'b0};
        tbl[1] = '{4'b0010, 5'd7,  5'd7,  1'b0};
        tbl[2] = '{4'b0100, 5'd12, 5'd12, 1'b0};
        tbl[3] = '{4'b1000, 5'd31, 5'd31, 1'b0};
        tbl[4] = '{4'b0110, 5'd11, 5'd0,  1'b1};
        tbl[5] = '{4'b0000, 5'd0,  5'd0,  1'b1};
        tbl[6] = '{4'b1111, 5'd23, 5'd0,  1'b1};
        tbl[7] = '{4'b0011, 5'd4,  5'd0,  1'b1};
        tbl[8] = '{4'b1001, 5'd28, 5'd0,  1'b1};
        tbl[9] = '{4'b1100, 5'd19, 5'd0,  1'b1};

        rstn = 1'b0;
        sw_in = base_in;
        in_src = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;

        // Reset state.
        next();
        check("rst_out_valid", 32'(ov0), 0);
        check("rst_sw_out", 32'(so0), 0);
        check("rst_sel_err", 32'(se0), 0);
        check("rst_err_cnt", 32'(ec0), 0);
        check("rst_err_cnt2", 32'(ec2), 0);
        next();
        rstn = 1'b1;
        chk_en = 1'b1;
        next();

        // Single-beat latency.
        in_valid = 1'b1;
        in_src = 4'b0100;
        next();
        in_valid = 1'b0;
        check("lat_c1_valid", 32'(ov0), 0);
        next();
        check("lat_c2_valid", 32'(ov0), 1);
        check("lat_c2_data", 32'(so0), 12);
        check("lat_c2_err", 32'(se0), 0);
        next();
        check("lat_c3_valid", 32'(ov0), 0);

        // Reset while a beat is in flight discards it.
        in_valid = 1'b1;
        next();
        in_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(ov0), 0);
        check("midrst_data", 32'(so0), 0);
        next();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            check("midrst_no_beat", 32'(ov0), 0);
        end

        // Stage-0 function table.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_src = tbl[i].src;
            next();
            in_valid = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                next();
                if (ov0) found = 1'b1;
            end
            if (!found) check("tbl_timeout", 0, 1);
            else begin
                check("tbl_xor_data", 32'(so0), 32'(tbl[i].d_xor));
                check("tbl_zero_data", 32'(so1), 32'(tbl[i].d_zero));
                check("tbl_sel_err", 32'(se0), 32'(tbl[i].err));
                check("tbl_sel_err1", 32'(se1), 32'(tbl[i].err));
            end
            next();
        end

        // Streaming: one beat per cycle in order.
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_src = (i < 4) ? 4'(1 << i) : 4'b0000;
            next();
            if (i >= 1 && i <= 4) begin
                check("stream_valid", 32'(ov0), 1);
                check("stream_data", 32'(so0), 32'(stream_exp[i-1]));
            end
        end
        in_valid = 1'b0;
        check("stream_err_cnt", 32'(ec0), 0);
        next();

        // Backpressure: hold output for three cycles, then resume.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_src = 4'(1 << i);
            next();
        end
        in_valid = 1'b0;
        check("bp_valid", 32'(ov0), 1);
        held = so0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_src = 4'b0001;
            next();
            check("bp_hold_data", 32'(so0), 32'(held));
            check("bp_hold_valid", 32'(ov0), 1);
            check("bp_in_ready", 32'(rdy0), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) next();

        // Counter saturation and clear priority.
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        in_valid = 1'b1;
        in_src = 4'b0000;
        repeat (5) next();
        in_valid = 1'b0;
        check("sat_cnt2", 32'(ec2), 3);
        check("sat_cnt8", 32'(ec0), 5);
        err_clr = 1'b1;
        in_valid = 1'b1;
        in_src = 4'b0110;
        next();
        err_clr = 1'b0;
        in_valid = 1'b0;
        check("clr_prio_cnt8", 32'(ec0), 0);
        check("clr_prio_cnt2", 32'(ec2), 0);
        repeat (4) next();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            in_valid = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 3))
                0, 1:    in_src = 4'(1 << $urandom_range(0, 3));
                2:       in_src = 4'($urandom);
                default: in_src = 4'(1 << $urandom_range(0, 3));
            endcase
            sw_in = 20'($urandom);
            out_ready = ($urandom_range(0, 99) < 65);
            err_clr = ($urandom_range(0, 99) < 3);
            next();
        end

        // Drain.
        rstn = 1'b1;
        in_valid = 1'b0;
        err_clr = 1'b0;
        out_ready = 1'b1;
        repeat (8) next();
        check("drain_empty", 32'(ov0), 0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
